// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: decode field layout, access
// size encodings, FSM states and the alignment rule.
package lsu_ctrl_pkg;

    localparam int unsigned LS_LOAD          = 0;
    localparam int unsigned LS_STORE         = 1;
    localparam int unsigned LS_SIZE_LSB      = 2;
    localparam int unsigned LS_SIZE_MSB      = 3;
    localparam int unsigned LS_UNSIGNED      = 4;
    localparam int unsigned LD_ST_INFO_WIDTH = 5;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } lsu_state_t;

    // size=3 is handled as a word access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and shift/extend of returned load data.
// Purely combinational.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      st_be,
    output logic [XLEN-1:0] st_wdata,
    input  logic [1:0]      ld_size,
    input  logic [1:0]      ld_off,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_B: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_off, 3'b000};
        ld_data = shifted;
        case (ld_size)
            SZ_B:    ld_data = {{(XLEN-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{(XLEN-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory stage: issues one load or store on a req/gnt/rvalid bus, stalls the
// pipeline while it is in flight and returns extended load data.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [LD_ST_INFO_WIDTH-1:0] ld_st_info_i,
    input  logic [XLEN-1:0]             mem_addr_i,
    input  logic [XLEN-1:0]             rs2_rdata_i,
    output logic                        stall_o,
    output logic [XLEN-1:0]             ld_rd_wdata_o,
    output logic                        done_o,
    output logic                        misalign_o,
    output logic [XLEN-1:0]             misalign_addr_o,
    output logic                        bus_req_o,
    output logic                        bus_we_o,
    output logic [XLEN-1:0]             bus_addr_o,
    output logic [3:0]                  bus_be_o,
    output logic [XLEN-1:0]             bus_wdata_o,
    input  logic                        bus_gnt_i,
    input  logic                        bus_rvalid_i,
    input  logic [XLEN-1:0]             bus_rdata_i
);

    lsu_state_t      state;
    logic [XLEN-1:2] addr_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;

    logic            in_load;
    logic            in_store;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic            access;
    logic            misaligned;
    logic            op_start;
    logic            mis_hit;

    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    assign in_load     = ld_st_info_i[LS_LOAD];
    assign in_store    = ld_st_info_i[LS_STORE];
    assign in_size     = ld_st_info_i[LS_SIZE_MSB:LS_SIZE_LSB];
    assign in_unsigned = ld_st_info_i[LS_UNSIGNED];

    assign access     = valid_i & (in_load | in_store) & (state == S_IDLE);
    assign misaligned = is_misaligned(in_size, mem_addr_i[1:0]);
    assign op_start   = access & ~misaligned;
    assign mis_hit    = access & misaligned;

    // Store side works on the live inputs (used in the start cycle and then
    // latched); load side works on the latched offset/size of the op in flight.
    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_size    (in_size),
        .st_off     (mem_addr_i[1:0]),
        .st_data    (rs2_rdata_i),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_size    (size_q),
        .ld_off     (off_q),
        .ld_unsigned(uns_q),
        .ld_rdata   (bus_rdata_i),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_start) begin
                        addr_q  <= mem_addr_i[XLEN-1:2];
                        off_q   <= mem_addr_i[1:0];
                        size_q  <= in_size;
                        uns_q   <= in_unsigned;
                        we_q    <= in_store;
                        be_q    <= st_be;
                        wdata_q <= st_wdata;
                        state   <= bus_gnt_i ? S_RESP : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_gnt_i) state <= S_RESP;
                end
                S_RESP: begin
                    if (bus_rvalid_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The start cycle drives the bus straight from the inputs so a same-cycle
    // grant needs no extra cycle; REQ replays the latched copy.
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        if (op_start) begin
            bus_req_o   = 1'b1;
            bus_we_o    = in_store;
            bus_addr_o  = {mem_addr_i[XLEN-1:2], 2'b00};
            bus_be_o    = st_be;
            bus_wdata_o = st_wdata;
        end else if (state == S_REQ) begin
            bus_req_o   = 1'b1;
            bus_we_o    = we_q;
            bus_addr_o  = {addr_q, 2'b00};
            bus_be_o    = be_q;
            bus_wdata_o = wdata_q;
        end
    end

    always_comb begin
        done_o          = (state == S_RESP) & bus_rvalid_i;
        stall_o         = op_start | (state == S_REQ) | ((state == S_RESP) & ~bus_rvalid_i);
        ld_rd_wdata_o   = (done_o & ~we_q) ? ld_data : '0;
        misalign_o      = mis_hit;
        misalign_addr_o = mis_hit ? mem_addr_i : '0;
    end

endmodule
